mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: ADDR_W, default 9, word-address width of the target on-chip memory (depth 2**ADDR_W = 512).
REQ-002 Parameter: DATA_W, default 32, data width of the target memory.
REQ-003 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  one-cycle command strobe; sampled only in IDLE.
REQ-006 Port: mode  in  1  0 = copy src->dst, 1 = fill dst with fill_data; sampled with start.
REQ-007 Port: src_addr  in  ADDR_W  first source word address; sampled with start.
REQ-008 Port: dst_addr  in  ADDR_W  first destination word address; sampled with start.
REQ-009 Port: length  in  ADDR_W+1  word count, legal 1..512; sampled with start.
REQ-010 Port: fill_data  in  DATA_W  fill pattern; sampled with start.
REQ-011 Port: abort  in  1  synchronous cancel of the running command.
REQ-012 Port: busy  out  1  high from the cycle after an accepted start until return to IDLE.
REQ-013 Port: done  out  1  one-cycle completion pulse.
REQ-014 Port: status  out  2  00 ok, 01 aborted, 10 illegal length; valid while done=1, held until next done.
REQ-015 Port: mem_address  out  ADDR_W  memory word address.
REQ-016 Port: mem_chipselect  out  1  memory access enable.
REQ-017 Port: mem_write  out  1  write strobe; only asserted with mem_chipselect.
REQ-018 Port: mem_byteenable  out  DATA_W/8  always all-ones while mem_chipselect=1, else 0.
REQ-019 Port: mem_writedata  out  DATA_W  write data.
REQ-020 Port: mem_readdata  in  DATA_W  memory read data, valid exactly 1 cycle after a read cycle (chipselect=1, write=0).

Function
REQ-021 The block SHALL implement FSM states IDLE, RD, WR, FILL, DONE.
REQ-022 In IDLE, start=1 with length 0 or >512 SHALL go to DONE with status 10 and no memory access.
REQ-023 In IDLE, legal start SHALL latch all command fields and go to RD (mode 0) or FILL (mode 1).
REQ-024 RD: chipselect=1, write=0, address=current src; next state WR.
REQ-025 WR: chipselect=1, write=1, address=current dst, mem_writedata=mem_readdata (combinational pass-through, the only input-to-output path); next state RD, or DONE after the last word.
REQ-026 FILL: chipselect=1, write=1, address=current dst, mem_writedata=latched fill_data; one word per cycle; DONE after the last word.
REQ-027 Throughput SHALL be exactly 2 cycles/word in copy, 1 cycle/word in fill; no idle cycles between words.
REQ-028 src and dst SHALL each increment by 1 after use, modulo 2**ADDR_W (511 wraps to 0).
REQ-029 Copy order SHALL always be ascending; overlapping ranges with dst>src SHALL propagate copied words (defined, not an error).
REQ-030 A remaining-word counter SHALL load length and decrement per written word; the last word is the one written with counter=1.
REQ-031 DONE SHALL last one cycle with done=1, busy=0, chipselect=0, then go to IDLE; start in DONE is ignored.
REQ-032 start while busy SHALL be ignored with no effect on the running command.
REQ-033 abort=1 in RD/WR/FILL SHALL suppress memory access in that cycle and go to DONE with status 01; words already written stay written; abort in IDLE/DONE is ignored.
REQ-034 abort and last-word in the same cycle: abort wins (the write is suppressed, status 01).
REQ-035 Outside RD/WR/FILL, mem_chipselect, mem_write, mem_byteenable SHALL be 0; mem_address and mem_writedata hold their last value.

Reset
REQ-036 reset=1 SHALL force IDLE within the same edge, overriding start and abort, and cancel any running command without a done pulse.
REQ-037 Reset values: busy=0, done=0, status=00, mem_chipselect=0, mem_write=0, mem_byteenable=0, mem_address=0, mem_writedata=0, counter and latched fields 0.

Verification
REQ-038 Fill: mode=1, dst=10, length=4, fill_data=0xA5A5_0001 -> writes at 10..13 on 4 consecutive cycles, done 1 cycle after the last write, status 00.
REQ-039 Copy: preload words 0..2 = 1,2,3; mode=0, src=0, dst=100, length=3 -> alternating RD/WR for 6 cycles, words 100..102 = 1,2,3, done, status 00.
REQ-040 Wrap: mode=1, dst=510, length=4 -> writes at 510, 511, 0, 1.
REQ-041 Illegal: length=0, then length=513 -> no chipselect, done next cycle, status 10 each time.
REQ-042 Abort/reset: abort during the 3rd word of an 8-word fill -> exactly 2 words written, status 01; repeating with reset instead -> IDLE, no done, all outputs at reset values.
REQ-043 Overlap: words 0..3 = 7,8,9,10; copy src=0, dst=1, length=3 -> words 1..3 all equal 7.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Word-oriented copy/fill engine for a single-port on-chip memory with 1-cycle read latency.
// Copy alternates one read and one write per word; fill writes one word per cycle.
module mem_copy_engine #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [ADDR_W-1:0]     dst_addr,
   input  logic [ADDR_W:0]       length,
   input  logic [DATA_W-1:0]     fill_data,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            status,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic [DATA_W-1:0]     mem_writedata,
   input  logic [DATA_W-1:0]     mem_readdata,
   output logic [2:0]            dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_FILL = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ABORT   = 2'b01;
   localparam logic [1:0] ST_ILLEGAL = 2'b10;

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_LEN = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]   fill_q, fill_d;
   logic [1:0]          status_q, status_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   logic                cs;
   logic                we;
   logic                len_illegal;

   assign len_illegal = (length == '0) || (length > MAX_LEN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         cnt_q    <= '0;
         fill_q   <= '0;
         status_q <= ST_OK;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         cnt_q    <= cnt_d;
         fill_q   <= fill_d;
         status_q <= status_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   // Address and write data fall back to the held registers whenever no access is made,
   // so they keep their last driven value in IDLE, DONE and aborted cycles.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      cnt_d    = cnt_q;
      fill_d   = fill_q;
      status_d = status_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cs       = 1'b0;
      we       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len_illegal) begin
                  status_d = ST_ILLEGAL;
                  state_d  = S_DONE;
               end else begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  cnt_d   = length;
                  fill_d  = fill_data;
                  state_d = mode ? S_FILL : S_RD;
               end
            end
         end

         S_RD: begin
            if (abort) begin
               status_d = ST_ABORT;
               state_d  = S_DONE;
            end else begin
               cs      = 1'b1;
               addr_d  = src_q;
               src_d   = src_q + ADDR_ONE;
               state_d = S_WR;
            end
         end

         S_WR: begin
            if (abort) begin
               status_d = ST_ABORT;
               state_d  = S_DONE;
            end else begin
               cs      = 1'b1;
               we      = 1'b1;
               addr_d  = dst_q;
               wdata_d = mem_readdata;
               dst_d   = dst_q + ADDR_ONE;
               cnt_d   = cnt_q - ONE_LEN;
               if (cnt_q == ONE_LEN) begin
                  status_d = ST_OK;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_RD;
               end
            end
         end

         S_FILL: begin
            if (abort) begin
               status_d = ST_ABORT;
               state_d  = S_DONE;
            end else begin
               cs      = 1'b1;
               we      = 1'b1;
               addr_d  = dst_q;
               wdata_d = fill_q;
               dst_d   = dst_q + ADDR_ONE;
               cnt_d   = cnt_q - ONE_LEN;
               if (cnt_q == ONE_LEN) begin
                  status_d = ST_OK;
                  state_d  = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy           = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_FILL);
   assign done           = (state_q == S_DONE);
   assign status         = status_q;
   assign mem_chipselect = cs;
   assign mem_write      = we;
   assign mem_byteenable = {(DATA_W/8){cs}};
   assign mem_address    = addr_d;
   assign mem_writedata  = wdata_d;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a behavioural 512-word memory with 1-cycle read
// latency sits on the memory port; each task drives one scenario and checks inline.
module tb_mem_copy_engine;
   localparam int AW = 9;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset, start, mode, abort;
   logic [AW-1:0]   src_addr, dst_addr;
   logic [AW:0]     length;
   logic [DW-1:0]   fill_data;
   logic            busy, done;
   logic [1:0]      status;
   logic [AW-1:0]   mem_address;
   logic            mem_chipselect, mem_write;
   logic [DW/8-1:0] mem_byteenable;
   logic [DW-1:0]   mem_writedata, mem_readdata;
   logic [2:0]      dbg_state;

   always #5 clk = ~clk;

   mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
      .status(status), .mem_address(mem_address),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .dbg_state_o(dbg_state)
   );

   // Memory model with a bench-side preload port.
   logic [DW-1:0] mem [0:511];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
      if (mem_chipselect && !mem_write) mem_readdata <= mem[mem_address];
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [AW-1:0] wr_addr_q[$];
   logic [DW-1:0] wr_data_q[$];
   int            wr_cyc_q[$];
   logic [AW-1:0] rd_addr_q[$];
   int            rd_cyc_q[$];
   int            done_cyc, bad_strobe, busy_bad;
   logic [1:0]    done_status;
   logic [AW-1:0] done_addr;
   logic [DW-1:0] done_wdata;

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic start_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW:0] len, input logic [DW-1:0] f);
      @(negedge clk);
      start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len; fill_data = f;
   endtask

   // Observes up to budget cycles; optionally pulses abort, reset or a second start at given cycles.
   task automatic run_cmd(input int budget, input int abort_at, input int reset_at, input int restart_at);
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      rd_addr_q.delete(); rd_cyc_q.delete();
      done_cyc = -1; bad_strobe = 0; busy_bad = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         abort = (i == abort_at);
         reset = (i == reset_at);
         if (i == restart_at) begin
            start = 1'b1; mode = 1'b1; dst_addr = 9'd300; length = 10'd1; fill_data = 32'hFFFF_FFFF;
         end else begin
            start = 1'b0;
         end
         #1;
         if (mem_write && !mem_chipselect) bad_strobe++;
         if (mem_byteenable !== {(DW/8){mem_chipselect}}) bad_strobe++;
         if ((reset_at < 0 || i <= reset_at) && (busy === done)) busy_bad++;
         if (mem_chipselect && mem_write) begin
            wr_addr_q.push_back(mem_address); wr_data_q.push_back(mem_writedata); wr_cyc_q.push_back(i);
         end
         if (mem_chipselect && !mem_write) begin
            rd_addr_q.push_back(mem_address); rd_cyc_q.push_back(i);
         end
         if (done) begin
            done_cyc = i; done_status = status; done_addr = mem_address; done_wdata = mem_writedata;
            break;
         end
      end
      @(negedge clk);
      abort = 1'b0; reset = 1'b0; start = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (status !== 2'b00) $display("FAIL reset_status: got %b want 00", status); else pass_cnt++;
      total_cnt++; if ({mem_chipselect, mem_write, mem_byteenable} !== 6'b0)
         $display("FAIL reset_strobes: got %b want 000000", {mem_chipselect, mem_write, mem_byteenable}); else pass_cnt++;
      total_cnt++; if (mem_address !== '0 || mem_writedata !== '0)
         $display("FAIL reset_addr_data: got %h/%h want 0/0", mem_address, mem_writedata); else pass_cnt++;
      total_cnt++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
   endtask

   task automatic test_fill();
      start_cmd(1'b1, 9'd0, 9'd10, 10'd4, 32'hA5A5_0001);
      run_cmd(20, -1, -1, -1);
      total_cnt++; if (wr_addr_q.size() != 4) $display("FAIL fill_count: got %0d want 4", wr_addr_q.size()); else pass_cnt++;
      for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
         total_cnt++;
         if (wr_addr_q[k] !== 9'(10 + k) || wr_data_q[k] !== 32'hA5A5_0001 || wr_cyc_q[k] != k)
            $display("FAIL fill_word%0d: got addr %0d data %h cyc %0d want addr %0d data a5a50001 cyc %0d",
                     k, wr_addr_q[k], wr_data_q[k], wr_cyc_q[k], 10 + k, k);
         else pass_cnt++;
      end
      total_cnt++; if (done_cyc != 4) $display("FAIL fill_done_cyc: got %0d want 4", done_cyc); else pass_cnt++;
      total_cnt++; if (done_status !== 2'b00) $display("FAIL fill_status: got %b want 00", done_status); else pass_cnt++;
      total_cnt++; if (done_addr !== 9'd13 || done_wdata !== 32'hA5A5_0001)
         $display("FAIL fill_hold: got %0d/%h want 13/a5a50001", done_addr, done_wdata); else pass_cnt++;
      total_cnt++; if (bad_strobe != 0 || busy_bad != 0)
         $display("FAIL fill_strobes: got %0d/%0d bad cycles want 0/0", bad_strobe, busy_bad); else pass_cnt++;
   endtask

   task automatic test_copy();
      preload(9'd0, 32'd1); preload(9'd1, 32'd2); preload(9'd2, 32'd3);
      start_cmd(1'b0, 9'd0, 9'd100, 10'd3, 32'h0);
      run_cmd(30, -1, -1, -1);
      total_cnt++; if (rd_addr_q.size() != 3 || wr_addr_q.size() != 3)
         $display("FAIL copy_count: got %0d reads %0d writes want 3/3", rd_addr_q.size(), wr_addr_q.size()); else pass_cnt++;
      for (int k = 0; k < 3 && k < rd_addr_q.size() && k < wr_addr_q.size(); k++) begin
         total_cnt++;
         if (rd_addr_q[k] !== 9'(k) || rd_cyc_q[k] != 2 * k || wr_addr_q[k] !== 9'(100 + k) ||
             wr_data_q[k] !== 32'(k + 1) || wr_cyc_q[k] != 2 * k + 1)
            $display("FAIL copy_word%0d: got rd %0d@%0d wr %0d=%0d@%0d want rd %0d@%0d wr %0d=%0d@%0d", k,
                     rd_addr_q[k], rd_cyc_q[k], wr_addr_q[k], wr_data_q[k], wr_cyc_q[k],
                     k, 2 * k, 100 + k, k + 1, 2 * k + 1);
         else pass_cnt++;
      end
      total_cnt++; if (done_cyc != 6 || done_status !== 2'b00)
         $display("FAIL copy_done: got cyc %0d status %b want 6/00", done_cyc, done_status); else pass_cnt++;
      total_cnt++; if (mem[100] !== 32'd1 || mem[101] !== 32'd2 || mem[102] !== 32'd3)
         $display("FAIL copy_mem: got %0d,%0d,%0d want 1,2,3", mem[100], mem[101], mem[102]); else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_a [4];
      exp_a[0] = 9'd510; exp_a[1] = 9'd511; exp_a[2] = 9'd0; exp_a[3] = 9'd1;
      start_cmd(1'b1, 9'd0, 9'd510, 10'd4, 32'h1234_5678);
      run_cmd(20, -1, -1, -1);
      total_cnt++; if (wr_addr_q.size() != 4) $display("FAIL wrap_count: got %0d want 4", wr_addr_q.size()); else pass_cnt++;
      for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
         total_cnt++;
         if (wr_addr_q[k] !== exp_a[k]) $display("FAIL wrap_addr%0d: got %0d want %0d", k, wr_addr_q[k], exp_a[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_illegal();
      logic [AW:0] lens [2];
      lens[0] = 10'd0; lens[1] = 10'd513;
      for (int k = 0; k < 2; k++) begin
         start_cmd(1'b1, 9'd0, 9'd50, lens[k], 32'h5555_5555);
         run_cmd(10, -1, -1, -1);
         total_cnt++;
         if (done_cyc != 0 || done_status !== 2'b10 || wr_addr_q.size() != 0 || rd_addr_q.size() != 0 || bad_strobe != 0)
            $display("FAIL illegal_len%0d: got done %0d status %b accesses %0d want 0/10/0",
                     lens[k], done_cyc, done_status, wr_addr_q.size() + rd_addr_q.size() + bad_strobe);
         else pass_cnt++;
      end
   endtask

   task automatic test_max_len();
      start_cmd(1'b1, 9'd0, 9'd0, 10'd512, 32'hCAFE_0000);
      run_cmd(600, -1, -1, -1);
      total_cnt++;
      if (wr_addr_q.size() != 512 || done_cyc != 512 || done_status !== 2'b00)
         $display("FAIL maxlen: got %0d writes done %0d status %b want 512/512/00", wr_addr_q.size(), done_cyc, done_status);
      else pass_cnt++;
      total_cnt++;
      if (wr_addr_q.size() != 512 || wr_addr_q[0] !== 9'd0 || wr_addr_q[511] !== 9'd511)
         $display("FAIL maxlen_ends: got %0d writes want 512 spanning 0..511", wr_addr_q.size());
      else pass_cnt++;
   endtask

   task automatic test_abort();
      preload(9'd22, 32'hDEAD_BEEF);
      start_cmd(1'b1, 9'd0, 9'd20, 10'd8, 32'h0F0F_0F0F);
      run_cmd(20, 2, -1, -1);
      total_cnt++; if (wr_addr_q.size() != 2) $display("FAIL abort_count: got %0d want 2", wr_addr_q.size()); else pass_cnt++;
      total_cnt++; if (done_cyc != 3 || done_status !== 2'b01)
         $display("FAIL abort_done: got cyc %0d status %b want 3/01", done_cyc, done_status); else pass_cnt++;
      total_cnt++; if (mem[20] !== 32'h0F0F_0F0F || mem[21] !== 32'h0F0F_0F0F || mem[22] !== 32'hDEAD_BEEF)
         $display("FAIL abort_mem: got %h,%h,%h want 0f0f0f0f,0f0f0f0f,deadbeef", mem[20], mem[21], mem[22]); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      start_cmd(1'b1, 9'd0, 9'd40, 10'd8, 32'h7777_7777);
      run_cmd(6, -1, 2, -1);
      total_cnt++; if (done_cyc != -1) $display("FAIL rstmid_done: got done at %0d want none", done_cyc); else pass_cnt++;
      total_cnt++; if (wr_addr_q.size() < 2 || wr_addr_q[0] !== 9'd40 || wr_addr_q[1] !== 9'd41)
         $display("FAIL rstmid_writes: got %0d writes want first two at 40,41", wr_addr_q.size()); else pass_cnt++;
      test_reset();
   endtask

   task automatic test_start_ignored();
      start_cmd(1'b1, 9'd0, 9'd60, 10'd3, 32'h0000_0011);
      run_cmd(20, -1, -1, 1);
      total_cnt++;
      if (wr_addr_q.size() != 3 || done_cyc != 3 || done_status !== 2'b00 || wr_addr_q[2] !== 9'd62 || wr_data_q[2] !== 32'h11)
         $display("FAIL busy_start: got %0d writes done %0d status %b want 3/3/00 ending at 62", wr_addr_q.size(), done_cyc, done_status);
      else pass_cnt++;
      start_cmd(1'b1, 9'd0, 9'd70, 10'd3, 32'h0000_0022);
      run_cmd(20, -1, -1, 3);
      total_cnt++; if (done_cyc != 3 || busy !== 1'b0 || dbg_state !== 3'd0)
         $display("FAIL done_start: got done %0d busy %b state %0d want 3/0/0", done_cyc, busy, dbg_state); else pass_cnt++;
   endtask

   task automatic test_overlap();
      preload(9'd0, 32'd7); preload(9'd1, 32'd8); preload(9'd2, 32'd9); preload(9'd3, 32'd10);
      start_cmd(1'b0, 9'd0, 9'd1, 10'd3, 32'h0);
      run_cmd(30, -1, -1, -1);
      total_cnt++; if (done_cyc != 6 || done_status !== 2'b00)
         $display("FAIL overlap_done: got cyc %0d status %b want 6/00", done_cyc, done_status); else pass_cnt++;
      total_cnt++; if (mem[1] !== 32'd7 || mem[2] !== 32'd7 || mem[3] !== 32'd7)
         $display("FAIL overlap_mem: got %0d,%0d,%0d want 7,7,7", mem[1], mem[2], mem[3]); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
      src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      test_reset();
      test_fill();
      test_copy();
      test_wrap();
      test_illegal();
      test_max_len();
      test_abort();
      test_reset_mid();
      test_start_ignored();
      test_overlap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
